// File: rtl/shell_sync_debounce.sv
// Multi-channel async-input synchronizer with a per-channel glitch filter.
// Each din bit is synchronized, then dout follows only after the change persists for FILTER_CYCLES cycles.
module shell_sync_debounce #(
   parameter int unsigned      WIDTH         = 8,
   parameter int unsigned      DEPTH         = 2,
   parameter int unsigned      FILTER_CYCLES = 4,
   parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [WIDTH-1:0] busy
);

   localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);

   // First stage samples the raw async input: timing false path, keep it intact.
   (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] meta_d;
   logic [WIDTH-1:0] sync_q [1:DEPTH-1];
   logic [WIDTH-1:0] sync_d [1:DEPTH-1];
   logic [WIDTH-1:0] s;

   logic [WIDTH-1:0] dout_q, dout_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic [WIDTH-1:0] busy_q, busy_d;

   always_comb begin
      meta_d    = din;
      sync_d[1] = meta_q;
      for (int unsigned k = 2; k < DEPTH; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

   assign s = sync_q[DEPTH-1];

   generate
      if (FILTER_CYCLES == 1) begin : g_direct
         always_comb begin
            dout_d = s;
            rise_d = s & ~dout_q;
            fall_d = ~s & dout_q;
            busy_d = '0;
         end
      end else begin : g_filt
         logic [CW-1:0] cnt_q [WIDTH];
         logic [CW-1:0] cnt_d [WIDTH];

         // A matching sample discards any partial qualification.
         always_comb begin
            dout_d = dout_q;
            rise_d = '0;
            fall_d = '0;
            busy_d = '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
               cnt_d[i] = '0;
               if (s[i] != dout_q[i]) begin
                  if (cnt_q[i] == CW'(FILTER_CYCLES - 1)) begin
                     dout_d[i] = s[i];
                     rise_d[i] = s[i];
                     fall_d[i] = ~s[i];
                  end else begin
                     cnt_d[i] = cnt_q[i] + CW'(1);
                  end
               end
               busy_d[i] = (cnt_d[i] != '0);
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int unsigned i = 0; i < WIDTH; i++) begin
                  cnt_q[i] <= '0;
               end
            end else begin
               for (int unsigned i = 0; i < WIDTH; i++) begin
                  cnt_q[i] <= cnt_d[i];
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         for (int unsigned k = 1; k < DEPTH; k++) begin
            sync_q[k] <= RESET_VAL;
         end
         dout_q <= RESET_VAL;
         rise_q <= '0;
         fall_q <= '0;
         busy_q <= '0;
      end else begin
         meta_q <= meta_d;
         for (int unsigned k = 1; k < DEPTH; k++) begin
            sync_q[k] <= sync_d[k];
         end
         dout_q <= dout_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         busy_q <= busy_d;
      end
   end

   assign dout = dout_q;
   assign rise = rise_q;
   assign fall = fall_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_shell_sync_debounce.sv
// Scoreboard bench for shell_sync_debounce: a queue-based reference model predicts each cycle,
// and a separate monitor compares the DUT against it. A second instance covers FILTER_CYCLES=1.
module tb_shell_sync_debounce;

   localparam int FC    = 4;
   localparam int DEP   = 2;
   localparam logic [7:0] RV = 8'h00;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] din, dout, rise, fall, busy;
   logic [7:0] din6, dout6, rise6, fall6, busy6;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] dout;
      logic [7:0] rise;
      logic [7:0] fall;
      logic [7:0] busy;
   } exp_t;

   exp_t       sbq[$];
   logic [7:0] stg[$];
   logic [7:0] m_dout;
   int         m_run[8];

   always #5 clk = ~clk;

   shell_sync_debounce #(
      .WIDTH(8), .DEPTH(DEP), .FILTER_CYCLES(FC), .RESET_VAL(RV)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .din(din),
      .dout(dout), .rise(rise), .fall(fall), .busy(busy)
   );

   shell_sync_debounce #(
      .WIDTH(8), .DEPTH(3), .FILTER_CYCLES(1), .RESET_VAL(8'hFF)
   ) u_dut6 (
      .clk(clk), .rst_n(rst_n), .din(din6),
      .dout(dout6), .rise(rise6), .fall(fall6), .busy(busy6)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      stg.delete();
      for (int k = 0; k < DEP; k++) stg.push_back(RV);
      m_dout = RV;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
      sbq.delete();
   endtask

   // One clock edge: s is the value leaving the synchronizer, dout flips after FC consecutive mismatches.
   task automatic model_edge(input logic [7:0] d);
      logic [7:0] s;
      exp_t       e;
      s = stg[stg.size()-1];
      stg.push_front(d);
      void'(stg.pop_back());
      e.rise = '0;
      e.fall = '0;
      e.busy = '0;
      for (int i = 0; i < 8; i++) begin
         if (s[i] == m_dout[i]) begin
            m_run[i] = 0;
         end else begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == FC) begin
               m_dout[i] = s[i];
               m_run[i]  = 0;
               if (s[i]) e.rise[i] = 1'b1;
               else      e.fall[i] = 1'b1;
            end
         end
         e.busy[i] = (m_run[i] != 0);
      end
      e.dout = m_dout;
      sbq.push_back(e);
   endtask

   task automatic step(input logic [7:0] d);
      @(negedge clk);
      din = d;
      model_edge(d);
   endtask

   task automatic release_rst(input logic [7:0] d);
      @(negedge clk);
      rst_n = 1'b1;
      din   = d;
      model_edge(d);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if ({dout, rise, fall, busy} !== e) begin
               errors++;
               $display("FAIL scoreboard t=%0t dout=%h/%h rise=%h/%h fall=%h/%h busy=%h/%h (got/expected)",
                        $time, dout, e.dout, rise, e.rise, fall, e.fall, busy, e.busy);
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog t=%0t simulation did not complete", $time);
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [7:0] d;
      rst_n = 1'b0;
      din   = 8'h00;
      din6  = 8'hFF;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_dout", dout, 8'h00);
      chk("reset_rise", rise, 8'h00);
      chk("reset_fall", fall, 8'h00);
      chk("reset_busy", busy, 8'h00);
      chk("reset_dout6", dout6, 8'hFF);
      release_rst(8'h00);

      // Single channel rise, then return low.
      repeat (8) step(8'h01);
      repeat (8) step(8'h00);
      // Glitch one cycle short of qualifying, then exactly qualifying.
      repeat (3) step(8'h08);
      repeat (6) step(8'h00);
      repeat (4) step(8'h08);
      repeat (8) step(8'h00);
      // Multi-channel simultaneous edges.
      repeat (6) step(8'hA5);
      repeat (6) step(8'h5A);
      repeat (6) step(8'h00);

      // Reset while channel 1 is mid-qualification.
      repeat (4) step(8'h02);
      @(posedge clk);
      #2;
      chk("pre_reset_busy1", busy & 8'h02, 8'h02);
      rst_n = 1'b0;
      #1;
      chk("async_reset_dout", dout, 8'h00);
      chk("async_reset_rise", rise, 8'h00);
      chk("async_reset_fall", fall, 8'h00);
      chk("async_reset_busy", busy, 8'h00);
      model_reset();
      release_rst(8'h02);
      repeat (8) step(8'h02);

      // Randomized bit flips with mixed hold lengths.
      d = 8'h02;
      for (int n = 0; n < 600; n++) begin
         for (int b = 0; b < 8; b++) begin
            if ($urandom_range(0, 4) == 0) d[b] = ~d[b];
         end
         step(d);
      end
      repeat (8) step(d);

      // FILTER_CYCLES=1, DEPTH=3, RESET_VAL=0xFF instance.
      @(negedge clk);
      din6 = 8'h00;
      for (int e = 0; e < 3; e++) begin
         @(posedge clk);
         #1;
         chk("f1_dout_hold", dout6, 8'hFF);
         chk("f1_fall_idle", fall6, 8'h00);
         chk("f1_busy", busy6, 8'h00);
      end
      @(posedge clk);
      #1;
      chk("f1_dout_new", dout6, 8'h00);
      chk("f1_fall", fall6, 8'hFF);
      chk("f1_rise", rise6, 8'h00);
      @(posedge clk);
      #1;
      chk("f1_fall_once", fall6, 8'h00);
      chk("f1_busy_end", busy6, 8'h00);

      chk("scoreboard_drained", 8'(sbq.size()), 8'h00);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
